// File: rtl/axis_mux_arb.sv
`default_nettype none
// ============================================================================
// axis_mux_arb : packet-locking NUM_CH:1 AXI4-Stream mux, registered output
// Rev 1.0
// ============================================================================
module axis_mux_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int ARB_MODE   = 0,
  parameter int SEL_W      = $clog2(NUM_CH)
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_CH-1:0]            s_tvalid,
  input  logic [NUM_CH-1:0]            s_tlast,
  output logic [NUM_CH-1:0]            s_tready,
  input  logic [SEL_W-1:0]             sel,
  output logic [DATA_WIDTH-1:0]        m_tdata,
  output logic                         m_tvalid,
  output logic                         m_tlast,
  input  logic                         m_tready,
  output logic [SEL_W-1:0]             active_ch,
  output logic                         busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SEL_W-1:0]        r_active_ch;
  logic [DATA_WIDTH-1:0]   r_m_tdata;
  logic                    r_m_tvalid;
  logic                    r_m_tlast;

  logic [DATA_WIDTH-1:0]   w_ch_data [NUM_CH];
  logic                    w_req_vld;
  logic [SEL_W-1:0]        w_req_ch;
  logic                    w_out_free;
  logic                    w_accept;
  logic                    w_grant;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign w_ch_data[gi] = s_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Request decode: either the external select or a rotating-priority search.
  generate
    if (ARB_MODE == 1) begin : g_rr
      logic [SEL_W-1:0] r_rr_base;
      logic             w_unused_sel;

      assign w_unused_sel = ^sel;

      // Reverse walk so the lowest offset from r_rr_base is the final winner.
      always_comb begin
        w_req_vld = 1'b0;
        w_req_ch  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (s_tvalid[SEL_W'((int'(r_rr_base) + i) % NUM_CH)]) begin
            w_req_vld = 1'b1;
            w_req_ch  = SEL_W'((int'(r_rr_base) + i) % NUM_CH);
          end
        end
      end

      always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
          r_rr_base <= '0;
        end else if (w_grant) begin
          r_rr_base <= SEL_W'((int'(w_req_ch) + 1) % NUM_CH);
        end
      end
    end else begin : g_ext
      always_comb begin
        w_req_ch  = sel;
        w_req_vld = 1'b0;
        if (int'(sel) < NUM_CH) begin
          w_req_vld = s_tvalid[sel];
        end
      end
    end
  endgenerate

  assign w_out_free = !r_m_tvalid || m_tready;
  assign w_grant    = (r_state == ST_IDLE) && w_req_vld;
  assign w_accept   = (r_state == ST_PKT) && s_tvalid[r_active_ch] && w_out_free;

  always_comb begin
    s_tready = '0;
    if (r_state == ST_PKT) begin
      s_tready[r_active_ch] = w_out_free;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_req_vld) w_state_nxt = ST_PKT;
      ST_PKT:  if (w_accept && s_tlast[r_active_ch]) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= ST_IDLE;
      r_active_ch <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_active_ch <= w_req_ch;
      end
    end
  end

  // Output register: load on an accepted beat, otherwise clear valid once drained.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
    end else if (w_accept) begin
      r_m_tdata  <= w_ch_data[r_active_ch];
      r_m_tlast  <= s_tlast[r_active_ch];
      r_m_tvalid <= 1'b1;
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_tdata   = r_m_tdata;
  assign m_tvalid  = r_m_tvalid;
  assign m_tlast   = r_m_tlast;
  assign active_ch = r_active_ch;
  assign busy      = (r_state == ST_PKT);

endmodule
`default_nettype wire

// File: tb/tb_axis_mux_arb.sv
`default_nettype none
// ============================================================================
// tb_axis_mux_arb : bench for axis_mux_arb (external-select and round-robin)
// Rev 1.0
// ============================================================================
module tb_axis_mux_arb;

  logic ACLK;
  logic ARESETn;

  // Instance 0: external select
  logic [31:0] s0_tdata;
  logic [3:0]  s0_tvalid, s0_tlast, s0_tready;
  logic [1:0]  sel0, active0;
  logic [7:0]  m0_tdata;
  logic        m0_tvalid, m0_tlast, m0_tready, busy0;

  // Instance 1: round robin
  logic [31:0] s1_tdata;
  logic [3:0]  s1_tvalid, s1_tlast, s1_tready;
  logic [1:0]  sel1, active1;
  logic [7:0]  m1_tdata;
  logic        m1_tvalid, m1_tlast, m1_tready, busy1;

  axis_mux_arb #(.DATA_WIDTH(8), .NUM_CH(4), .ARB_MODE(0)) u_dut0 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tdata(s0_tdata), .s_tvalid(s0_tvalid), .s_tlast(s0_tlast), .s_tready(s0_tready),
    .sel(sel0),
    .m_tdata(m0_tdata), .m_tvalid(m0_tvalid), .m_tlast(m0_tlast), .m_tready(m0_tready),
    .active_ch(active0), .busy(busy0)
  );

  axis_mux_arb #(.DATA_WIDTH(8), .NUM_CH(4), .ARB_MODE(1)) u_dut1 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tdata(s1_tdata), .s_tvalid(s1_tvalid), .s_tlast(s1_tlast), .s_tready(s1_tready),
    .sel(sel1),
    .m_tdata(m1_tdata), .m_tvalid(m1_tvalid), .m_tlast(m1_tlast), .m_tready(m1_tready),
    .active_ch(active1), .busy(busy1)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // ---------------- table vectors for the external-select instance ----------------
  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic [31:0] dat;
    logic        mrdy;
    logic [3:0]  e_srdy;
    logic        e_mv;
    logic [7:0]  e_md;
    logic        e_ml;
    logic        e_busy;
    logic [1:0]  e_act;
  } vec_t;

  vec_t tv[$];

  task automatic add_v(input logic [1:0] s, input logic [3:0] v, input logic [3:0] l,
                       input logic [31:0] d, input logic mr, input logic [3:0] er,
                       input logic emv, input logic [7:0] emd, input logic eml,
                       input logic eb, input logic [1:0] ea);
    vec_t x;
    x.sel = s; x.vld = v; x.lst = l; x.dat = d; x.mrdy = mr;
    x.e_srdy = er; x.e_mv = emv; x.e_md = emd; x.e_ml = eml; x.e_busy = eb; x.e_act = ea;
    tv.push_back(x);
  endtask

  // ---------------- source / reference model for the round-robin instance ----------
  logic [7:0] sm_d [4][512];
  logic       sm_l [4][512];
  int         wr[4], rd[4], erd[4];
  int         exp_ch;
  int         n_out;
  bit         sb_en;
  logic       prev_busy1;
  int         grants[$];

  task automatic reset_model();
    for (int c = 0; c < 4; c++) begin
      wr[c] = 0; rd[c] = 0; erd[c] = 0;
    end
    exp_ch = 0; n_out = 0; prev_busy1 = 1'b0;
    grants.delete();
  endtask

  task automatic add_pkt(input int c, input int len, input logic [7:0] base, input bit rnd);
    for (int k = 0; k < len; k++) begin
      sm_d[c][wr[c]] = rnd ? 8'($urandom) : base + 8'(k);
      sm_l[c][wr[c]] = (k == len - 1);
      wr[c]++;
    end
  endtask

  // One clock of the round-robin instance: drive sources, check handshakes and
  // compare every transferred beat with the expected packet stream.
  task automatic cyc1(input bit gaps, input int rpct);
    logic [3:0] v, rdy;
    logic       mv, ml, mr;
    logic [7:0] md;
    v = '0;
    for (int c = 0; c < 4; c++) begin
      s1_tdata[c*8 +: 8] = 8'h00;
      s1_tlast[c]        = 1'b0;
      if (rd[c] < wr[c]) begin
        v[c] = 1'b1;
        if (gaps && rd[c] > 0 && !sm_l[c][rd[c]-1] && $urandom_range(3) == 0) v[c] = 1'b0;
        s1_tdata[c*8 +: 8] = sm_d[c][rd[c]];
        s1_tlast[c]        = sm_l[c][rd[c]];
      end
    end
    s1_tvalid = v;
    m1_tready = ($urandom_range(99) < rpct);
    #1;
    rdy = s1_tready; mv = m1_tvalid; md = m1_tdata; ml = m1_tlast; mr = m1_tready;
    chk("srdy_onehot", ($countones(rdy) <= 1), 1);
    @(posedge ACLK); #1;
    for (int c = 0; c < 4; c++) if (v[c] && rdy[c]) rd[c]++;
    if (mv && mr && sb_en) begin
      n_out++;
      chk("sb_avail", (erd[exp_ch] < wr[exp_ch]), 1);
      if (erd[exp_ch] < wr[exp_ch]) begin
        chk($sformatf("sb_data_ch%0d", exp_ch), md, sm_d[exp_ch][erd[exp_ch]]);
        chk($sformatf("sb_last_ch%0d", exp_ch), ml, sm_l[exp_ch][erd[exp_ch]]);
        erd[exp_ch]++;
        if (sm_l[exp_ch][erd[exp_ch]-1]) exp_ch = (exp_ch + 1) % 4;
      end
    end
    if (mv && !mr) chk("hold_stable", {m1_tvalid, m1_tlast, m1_tdata}, {1'b1, ml, md});
    if (busy1 && !prev_busy1) grants.push_back(int'(active1));
    prev_busy1 = busy1;
  endtask

  task automatic idle_inputs();
    s0_tdata = '0; s0_tvalid = '0; s0_tlast = '0; sel0 = '0; m0_tready = 1'b1;
    s1_tdata = '0; s1_tvalid = '0; s1_tlast = '0; sel1 = '0; m1_tready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    ARESETn = 1'b0;
    repeat (2) @(posedge ACLK);
    #3 ARESETn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    ARESETn = 1'b0;
    #7;
    chk("rst0_mvalid", m0_tvalid, 0);
    chk("rst0_mlast",  m0_tlast,  0);
    chk("rst0_mdata",  m0_tdata,  0);
    chk("rst0_busy",   busy0,     0);
    chk("rst0_active", active0,   0);
    chk("rst0_srdy",   s0_tready, 0);
    chk("rst1_mvalid", m1_tvalid, 0);
    chk("rst1_busy",   busy1,     0);
    chk("rst1_active", active1,   0);
    chk("rst1_srdy",   s1_tready, 0);
    do_reset();

    // sel=2 four-beat packet
    add_v(2, 4'b0100, 4'b0000, 32'hE3_11_E1_E0, 1, 4'b0000, 0, 8'h00, 0, 1, 2);
    add_v(2, 4'b0100, 4'b0000, 32'hE3_11_E1_E0, 1, 4'b0100, 1, 8'h11, 0, 1, 2);
    add_v(2, 4'b0100, 4'b0000, 32'hE3_12_E1_E0, 1, 4'b0100, 1, 8'h12, 0, 1, 2);
    add_v(2, 4'b0100, 4'b0000, 32'hE3_13_E1_E0, 1, 4'b0100, 1, 8'h13, 0, 1, 2);
    add_v(2, 4'b0100, 4'b0100, 32'hE3_14_E1_E0, 1, 4'b0100, 1, 8'h14, 1, 0, 2);
    add_v(2, 4'b0000, 4'b0000, 32'hE3_E2_E1_E0, 1, 4'b0000, 0, 8'h00, 0, 0, 2);
    // sel switches to 0 mid-packet while ch0 waits
    add_v(2, 4'b0101, 4'b0000, 32'hE3_21_E1_30, 1, 4'b0000, 0, 8'h00, 0, 1, 2);
    add_v(0, 4'b0101, 4'b0000, 32'hE3_21_E1_30, 1, 4'b0100, 1, 8'h21, 0, 1, 2);
    add_v(0, 4'b0101, 4'b0100, 32'hE3_22_E1_30, 1, 4'b0100, 1, 8'h22, 1, 0, 2);
    add_v(0, 4'b0001, 4'b0000, 32'hE3_E2_E1_30, 1, 4'b0000, 0, 8'h00, 0, 1, 0);
    add_v(0, 4'b0001, 4'b0001, 32'hE3_E2_E1_30, 1, 4'b0001, 1, 8'h30, 1, 0, 0);
    add_v(0, 4'b0000, 4'b0000, 32'hE3_E2_E1_E0, 1, 4'b0000, 0, 8'h00, 0, 0, 0);
    // backpressure on a six-beat packet from ch1
    add_v(1, 4'b0010, 4'b0000, 32'hE3_E2_A0_E0, 1, 4'b0000, 0, 8'h00, 0, 1, 1);
    add_v(1, 4'b0010, 4'b0000, 32'hE3_E2_A0_E0, 1, 4'b0010, 1, 8'hA0, 0, 1, 1);
    add_v(1, 4'b0010, 4'b0000, 32'hE3_E2_A1_E0, 1, 4'b0010, 1, 8'hA1, 0, 1, 1);
    add_v(1, 4'b0010, 4'b0000, 32'hE3_E2_A2_E0, 0, 4'b0000, 1, 8'hA1, 0, 1, 1);
    add_v(1, 4'b0010, 4'b0000, 32'hE3_E2_A2_E0, 0, 4'b0000, 1, 8'hA1, 0, 1, 1);
    add_v(1, 4'b0010, 4'b0000, 32'hE3_E2_A2_E0, 1, 4'b0010, 1, 8'hA2, 0, 1, 1);
    add_v(1, 4'b0010, 4'b0000, 32'hE3_E2_A3_E0, 0, 4'b0000, 1, 8'hA2, 0, 1, 1);
    add_v(1, 4'b0010, 4'b0000, 32'hE3_E2_A3_E0, 1, 4'b0010, 1, 8'hA3, 0, 1, 1);
    add_v(1, 4'b0010, 4'b0000, 32'hE3_E2_A4_E0, 1, 4'b0010, 1, 8'hA4, 0, 1, 1);
    add_v(1, 4'b0010, 4'b0010, 32'hE3_E2_A5_E0, 1, 4'b0010, 1, 8'hA5, 1, 0, 1);
    add_v(1, 4'b0000, 4'b0000, 32'hE3_E2_E1_E0, 0, 4'b0000, 1, 8'hA5, 1, 0, 1);
    add_v(1, 4'b0000, 4'b0000, 32'hE3_E2_E1_E0, 1, 4'b0000, 0, 8'h00, 0, 0, 1);
    // back-to-back single-beat packets on ch1
    add_v(1, 4'b0010, 4'b0010, 32'hE3_E2_B0_E0, 1, 4'b0000, 0, 8'h00, 0, 1, 1);
    add_v(1, 4'b0010, 4'b0010, 32'hE3_E2_B0_E0, 1, 4'b0010, 1, 8'hB0, 1, 0, 1);
    add_v(1, 4'b0010, 4'b0010, 32'hE3_E2_B1_E0, 1, 4'b0000, 0, 8'h00, 0, 1, 1);
    add_v(1, 4'b0010, 4'b0010, 32'hE3_E2_B1_E0, 1, 4'b0010, 1, 8'hB1, 1, 0, 1);
    add_v(1, 4'b0000, 4'b0000, 32'hE3_E2_E1_E0, 1, 4'b0000, 0, 8'h00, 0, 0, 1);

    for (int i = 0; i < tv.size(); i++) begin
      sel0 = tv[i].sel; s0_tvalid = tv[i].vld; s0_tlast = tv[i].lst;
      s0_tdata = tv[i].dat; m0_tready = tv[i].mrdy;
      #1;
      chk($sformatf("v%0d_srdy", i), s0_tready, tv[i].e_srdy);
      @(posedge ACLK); #1;
      chk($sformatf("v%0d_mvalid", i), m0_tvalid, tv[i].e_mv);
      chk($sformatf("v%0d_busy", i), busy0, tv[i].e_busy);
      chk($sformatf("v%0d_active", i), active0, tv[i].e_act);
      if (tv[i].e_mv) begin
        chk($sformatf("v%0d_mdata", i), m0_tdata, tv[i].e_md);
        chk($sformatf("v%0d_mlast", i), m0_tlast, tv[i].e_ml);
      end
    end

    // Round robin: all channels continuously valid with two-beat packets
    do_reset();
    reset_model();
    sb_en = 1'b1;
    for (int c = 0; c < 4; c++)
      for (int p = 0; p < 10; p++) add_pkt(c, 2, 8'(c * 16 + p * 2), 1'b0);
    for (int n = 0; n < 40 && grants.size() < 5; n++) cyc1(1'b0, 100);
    chk("rr_grants_seen", (grants.size() >= 5), 1);
    for (int k = 0; k < 5; k++)
      if (k < grants.size()) chk($sformatf("rr_grant%0d", k), grants[k], k % 4);

    // Randomized traffic: random lengths, data, mid-packet gaps and backpressure
    do_reset();
    reset_model();
    for (int c = 0; c < 4; c++)
      for (int p = 0; p < 40; p++) add_pkt(c, $urandom_range(1, 6), 8'h00, 1'b1);
    for (int n = 0; n < 500; n++) cyc1(1'b1, 70);
    chk("rand_progress", (n_out > 100), 1);

    // Asynchronous reset in the middle of a six-beat packet on ch2
    do_reset();
    reset_model();
    sb_en = 1'b0;
    add_pkt(2, 6, 8'hC0, 1'b0);
    for (int n = 0; n < 12 && rd[2] < 3; n++) cyc1(1'b0, 100);
    chk("arst_setup_beats", rd[2], 3);
    chk("arst_setup_busy", busy1, 1);
    #2 ARESETn = 1'b0;
    #1;
    chk("arst_mvalid", m1_tvalid, 0);
    chk("arst_mlast",  m1_tlast,  0);
    chk("arst_mdata",  m1_tdata,  0);
    chk("arst_busy",   busy1,     0);
    chk("arst_srdy",   s1_tready, 0);
    chk("arst_active", active1,   0);
    idle_inputs();
    repeat (2) @(posedge ACLK);
    #3 ARESETn = 1'b1;
    reset_model();
    sb_en = 1'b1;
    for (int c = 0; c < 4; c++)
      for (int p = 0; p < 2; p++) add_pkt(c, 3, 8'(8'h80 + c * 16 + p * 4), 1'b0);
    for (int n = 0; n < 20; n++) cyc1(1'b0, 100);
    chk("arst_regrant_seen", (grants.size() >= 1), 1);
    if (grants.size() >= 1) chk("arst_rr_restart", grants[0], 0);
    chk("arst_progress", (n_out > 6), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_mux_arb.md
# axis_mux_arb

Packet-aware N-to-1 AXI4-Stream multiplexer with a registered output stage and full per-channel TVALID/TREADY handshaking. Sits where the single-select 2:1 AXIS mux sat, generalised to NUM_CH inputs of DATA_WIDTH bits. Adds packet locking (a granted channel keeps the output until its TLAST beat transfers), backpressure to each source, and a choice of external-select or round-robin arbitration.

## Interface
- DATA_WIDTH, 8, TDATA width in bits (≥1)
- NUM_CH, 4, number of slave channels (2..16)
- ARB_MODE, 0, 0 = external select via sel; 1 = round-robin
- SEL_W, $clog2(NUM_CH), width of sel/active_ch (derived, do not override)

- ACLK  in  1  clock; all logic on rising edge
- ARESETn  in  1  reset, asynchronous, active-low
- s_tdata  in  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_tvalid  in  NUM_CH  per-channel TVALID
- s_tlast  in  NUM_CH  per-channel TLAST
- s_tready  out  NUM_CH  per-channel TREADY (combinational from state and m_ stage)
- sel  in  SEL_W  requested channel, ARB_MODE=0 only; ignored otherwise
- m_tdata  out  DATA_WIDTH  registered output data
- m_tvalid  out  1  registered output TVALID
- m_tlast  out  1  registered output TLAST
- m_tready  in  1  downstream TREADY
- active_ch  out  SEL_W  currently/last granted channel (registered)
- busy  out  1  high while a packet is locked (state PKT)

## Operation
- Two states: IDLE, PKT. Reset → IDLE.
- IDLE, ARB_MODE=0: if s_tvalid[sel], grant sel (active_ch←sel), go PKT; else stay. sel out of range (≥NUM_CH): no grant.
- IDLE, ARB_MODE=1: grant first i with s_tvalid[i], searching from (active_ch+1) mod NUM_CH upward with wrap; none valid → stay IDLE. After reset the search starts at channel 0.
- PKT: s_tready[active_ch] = !m_tvalid || m_tready; all other s_tready = 0. In IDLE all s_tready = 0.
- Input beat transfers when s_tvalid[g] && s_tready[g]: m_tdata←channel g data, m_tlast←s_tlast[g], m_tvalid←1.
- Output beat transfers when m_tvalid && m_tready; if no new input beat that cycle, m_tvalid←0 (m_tdata/m_tlast may hold).
- While m_tvalid && !m_tready: m_tdata, m_tlast, m_tvalid stable (AXIS rule).
- PKT → IDLE on the edge where the granted channel's TLAST beat is accepted into the output register. sel changes and other channels' TVALID during PKT are ignored.
- No data is dropped, duplicated or reordered; non-granted sources are stalled purely by s_tready=0.

## Timing
- Reset values: m_tdata=0, m_tvalid=0, m_tlast=0, active_ch=0, busy=0, s_tready=0 (all bits).
- Reset mid-packet: outputs forced to reset values immediately (asynchronous); packet truncated, no TLAST emitted; on release, arbitration restarts in IDLE.
- Arbitration: 1 cycle. s_tvalid seen in IDLE at edge k → busy=1 and s_tready[g]=1 from edge k.
- First beat: accepted at edge k+1, m_tvalid=1 after edge k+1 (2-cycle latency from request to output).
- Steady state with m_tready=1: 1 beat/cycle, no bubbles inside a packet.
- Between packets: exactly one bubble cycle on the input side (IDLE arbitration); output stage drains the TLAST beat concurrently.
- m_tready low: s_tready[g] drops in the same cycle once the output register is full; resumes the cycle m_tready returns.

## Test plan
- ARB_MODE=0, sel=2, ch2 sends 4-beat packet 0x11..0x14 (TLAST on 0x14), m_tready=1 → m_tdata 0x11,0x12,0x13,0x14 on consecutive cycles starting 2 cycles after request, m_tlast only on 0x14, busy falls after the TLAST accept.
- ARB_MODE=0, sel switched 2→0 mid-packet while ch0 valid → ch2 packet completes uninterrupted; ch0 granted only after one IDLE cycle; s_tready[0]=0 throughout ch2 packet.
- ARB_MODE=1, NUM_CH=4, all four channels continuously valid with 2-beat packets → grant order 0,1,2,3,0; no channel granted twice before others.
- Backpressure: m_tready toggled 1,0,0,1,0,1 during 6-beat packet 0xA0..0xA5 → output sequence exactly 0xA0..0xA5, no loss/duplication, m_tdata stable whenever m_tvalid&&!m_tready.
- ARESETn pulsed low asynchronously at beat 3 of a 6-beat packet → m_tvalid/m_tlast/busy/s_tready go 0 immediately; after release next packet from any channel arbitrates normally, round-robin restarts at ch0.
- Single-beat packets (TLAST on every beat) back-to-back on ch1 → one output beat every 2 cycles, each with m_tlast=1.
